// File: rtl/ram_map_buffer.sv
// ram_map_buffer: captures serial coded bits into a 1-bit RAM and drains them as BPS-bit mapper symbols.
// Define RAM_MAP_OVF_EN to add the sticky overflow output.
module ram_map_buffer #(
    parameter int MAPPER     = 16,
    parameter int ADDR_WIDTH = 14,
    parameter int DEPTH      = 16384
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      we,
    input  logic                      data_in,
    input  logic                      re,
    output logic [$clog2(MAPPER)-1:0] data_out,
    output logic                      valid_out,
    output logic                      busy,
    output logic                      empty
`ifdef RAM_MAP_OVF_EN
    ,
    output logic                      overflow
`endif
);

    localparam int BPS = $clog2(MAPPER);
    localparam int CW  = (BPS > 1) ? $clog2(BPS) : 1;
    localparam int PW  = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] FULL = PW'(DEPTH);
    localparam logic [PW-1:0] RND  = PW'(BPS - 1);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    state_t          r_state, w_state_nxt;
    logic            r_mem [DEPTH];
    logic            r_ram_q;
    logic            r_pad;
    logic            r_rd_vld;
    logic [PW-1:0]   r_wr_ptr, r_rd_ptr, r_frame_len, r_end, r_rcv;
    logic [CW-1:0]   r_cnt;
    logic [BPS-1:0]  r_asm;

    logic            w_wr_en, w_rd_en, w_start, w_last, w_emit, w_bit;
    logic [PW-1:0]   w_len_nxt;
    logic [BPS-1:0]  w_sym;

    assign w_wr_en   = we && ((r_state == IDLE) || ((r_state == FILL) && (r_wr_ptr != FULL)));
    assign w_start   = (r_state == FILL) && re;
    assign w_len_nxt = r_wr_ptr + PW'(w_wr_en);
    assign w_rd_en   = (r_state == DRAIN) && (r_rd_ptr != r_end);
    // Reads past frame_len fill the last symbol's LSBs with zeros, keeping the symbol cadence.
    assign w_bit     = r_ram_q & ~r_pad;
    assign w_emit    = r_rd_vld && (r_cnt == CW'(BPS - 1));
    assign w_last    = r_rd_vld && (r_rcv == r_end - PW'(1));

    assign busy  = (r_state == DRAIN);
    assign empty = (r_state == IDLE);

    always_comb begin
        w_sym = r_asm;
        for (int i = 0; i < BPS; i++) begin
            if (i == BPS - 1 - int'(r_cnt)) w_sym[i] = w_bit;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (we)     w_state_nxt = FILL;
            FILL:    if (re)     w_state_nxt = DRAIN;
            DRAIN:   if (w_last) w_state_nxt = IDLE;
            default:             w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // RAM contents are not reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= data_in;
        if (w_rd_en) r_ram_q <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_frame_len <= '0;
            r_end       <= '0;
            r_rcv       <= '0;
            r_cnt       <= '0;
            r_asm       <= '0;
            r_pad       <= 1'b0;
            r_rd_vld    <= 1'b0;
            data_out    <= '0;
            valid_out   <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            r_rd_vld  <= w_rd_en;
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_start) begin
                r_frame_len <= w_len_nxt;
                r_end       <= (w_len_nxt + RND) & ~RND;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
                r_pad    <= (r_rd_ptr >= r_frame_len);
            end
            if (r_rd_vld) begin
                r_rcv <= r_rcv + PW'(1);
                if (w_emit) begin
                    data_out  <= w_sym;
                    valid_out <= 1'b1;
                    r_asm     <= '0;
                    r_cnt     <= '0;
                end else begin
                    r_asm <= w_sym;
                    r_cnt <= r_cnt + CW'(1);
                end
            end
            if (w_last) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_rcv    <= '0;
            end
        end
    end

`ifdef RAM_MAP_OVF_EN
    logic r_ovf;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                             r_ovf <= 1'b0;
        else if (we && (r_state == FILL) && (r_wr_ptr == FULL)) r_ovf <= 1'b1;
    end

    assign overflow = r_ovf;
`endif

endmodule

// File: tb/tb_ram_map_buffer.sv
// Bench for ram_map_buffer: BPSK/QPSK/16-QAM instances driven with directed and random frames,
// symbols checked against a bit-grouping reference model.
module tb_ram_map_buffer;

    localparam int AW  = 14;
    localparam int DEP = 16384;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] we_s  = '0;
    logic [2:0] din_s = '0;
    logic [2:0] re_s  = '0;
    wire  [2:0] vld_s, bsy_s, emp_s;
    wire  [0:0] do_b;
    wire  [1:0] do_q;
    wire  [3:0] do_m;
`ifdef RAM_MAP_OVF_EN
    wire  [2:0] ovf_s;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit ref_q[$];

    always #5 clk = ~clk;

    ram_map_buffer #(.MAPPER(2), .ADDR_WIDTH(AW), .DEPTH(DEP)) u_bpsk (
        .clk(clk), .reset(reset), .we(we_s[0]), .data_in(din_s[0]), .re(re_s[0]),
        .data_out(do_b), .valid_out(vld_s[0]), .busy(bsy_s[0]), .empty(emp_s[0])
`ifdef RAM_MAP_OVF_EN
        , .overflow(ovf_s[0])
`endif
    );

    ram_map_buffer #(.MAPPER(4), .ADDR_WIDTH(AW), .DEPTH(DEP)) u_qpsk (
        .clk(clk), .reset(reset), .we(we_s[1]), .data_in(din_s[1]), .re(re_s[1]),
        .data_out(do_q), .valid_out(vld_s[1]), .busy(bsy_s[1]), .empty(emp_s[1])
`ifdef RAM_MAP_OVF_EN
        , .overflow(ovf_s[1])
`endif
    );

    ram_map_buffer #(.MAPPER(16), .ADDR_WIDTH(AW), .DEPTH(DEP)) u_qam (
        .clk(clk), .reset(reset), .we(we_s[2]), .data_in(din_s[2]), .re(re_s[2]),
        .data_out(do_m), .valid_out(vld_s[2]), .busy(bsy_s[2]), .empty(emp_s[2])
`ifdef RAM_MAP_OVF_EN
        , .overflow(ovf_s[2])
`endif
    );

    function automatic int bps_of(int idx);
        return (idx == 0) ? 1 : (idx == 1) ? 2 : 4;
    endfunction

    function automatic logic [3:0] dout_of(int idx);
        case (idx)
            0:       return {3'b000, do_b};
            1:       return {2'b00, do_q};
            default: return do_m;
        endcase
    endfunction

    // Symbol k = bits k*bps .. k*bps+bps-1 of the captured frame, first bit MSB, zeros past len.
    function automatic logic [3:0] exp_sym(int bps, int len, int k);
        logic [3:0] s = '0;
        for (int j = 0; j < bps; j++) begin
            if ((k * bps + j) < len && ref_q[k * bps + j]) s[bps - 1 - j] = 1'b1;
        end
        return s;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_frame(int idx, bit re_last);
        int n = ref_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            we_s[idx]  = 1'b1;
            din_s[idx] = ref_q[i];
            re_s[idx]  = re_last && (i == n - 1);
        end
        if (!re_last) begin
            @(negedge clk);
            we_s[idx] = 1'b0;
            re_s[idx] = 1'b1;
        end
    endtask

    // Cycle c counts negedges after the edge T0 that sampled re.
    task automatic run_frame(int idx, bit re_last, string tag);
        int bps = bps_of(idx);
        int len = (ref_q.size() > DEP) ? DEP : ref_q.size();
        int nsym = (len + bps - 1) / bps;
        int got = 0;
        int prev = 0;
        logic [3:0] last_sym = '0;
        drive_frame(idx, re_last);
        for (int c = 0; c < (nsym + 1) * bps + 6; c++) begin
            @(negedge clk);
            if (c == 0) begin
                we_s[idx] = 1'b0;
                re_s[idx] = 1'b0;
            end
            if (vld_s[idx]) begin
                if (got == 0) check({tag, " first_latency"}, 32'(c), 32'(bps + 1));
                else          check({tag, " spacing"}, 32'(c - prev), 32'(bps));
                last_sym = exp_sym(bps, len, got);
                check({tag, " symbol"}, 32'(dout_of(idx)), 32'(last_sym));
                if (got == nsym - 1) check({tag, " busy_at_last"}, 32'(bsy_s[idx]), 32'(0));
                got++;
                prev = c;
            end
        end
        check({tag, " symbol_count"}, 32'(got), 32'(nsym));
        check({tag, " busy_end"}, 32'(bsy_s[idx]), 32'(0));
        check({tag, " empty_end"}, 32'(emp_s[idx]), 32'(1));
        check({tag, " data_out_hold"}, 32'(dout_of(idx)), 32'(last_sym));
    endtask

    initial begin
        int got;
        int sawv;
        int sawb;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("reset valid_out", 32'(vld_s[k]), 32'(0));
            check("reset busy", 32'(bsy_s[k]), 32'(0));
            check("reset empty", 32'(emp_s[k]), 32'(1));
            check("reset data_out", 32'(dout_of(k)), 32'(0));
`ifdef RAM_MAP_OVF_EN
            check("reset overflow", 32'(ovf_s[k]), 32'(0));
`endif
        end
        @(negedge clk);
        reset = 1'b1;

        ref_q = '{1, 0, 1, 1, 0, 1};
        run_frame(1, 1'b0, "qpsk6");
        ref_q = '{1, 1, 0, 1, 1, 0};
        run_frame(2, 1'b0, "qam16_pad");
        ref_q = '{0, 1, 1, 0, 1};
        run_frame(0, 1'b1, "bpsk_re_with_write");

        // re with nothing captured must be ignored.
        sawv = 0;
        sawb = 0;
        @(negedge clk);
        re_s[2] = 1'b1;
        @(negedge clk);
        re_s[2] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (vld_s[2]) sawv++;
            if (bsy_s[2]) sawb++;
        end
        check("idle_re valid_count", 32'(sawv), 32'(0));
        check("idle_re busy_count", 32'(sawb), 32'(0));
        check("idle_re empty", 32'(emp_s[2]), 32'(1));

        for (int r = 0; r < 9; r++) begin
            int n = $urandom_range(1, 40);
            ref_q = {};
            for (int i = 0; i < n; i++) ref_q.push_back(1'($urandom_range(0, 1)));
            run_frame(r % 3, 1'($urandom_range(0, 1)), "random");
        end

        // Abort a drain with reset after three symbols.
        ref_q = {};
        for (int i = 0; i < 12; i++) ref_q.push_back(1'($urandom_range(0, 1)));
        drive_frame(1, 1'b0);
        got = 0;
        for (int c = 0; c < 30 && got < 3; c++) begin
            @(negedge clk);
            if (c == 0) begin
                we_s[1] = 1'b0;
                re_s[1] = 1'b0;
            end
            if (vld_s[1]) got++;
        end
        check("middrain symbols_before_reset", 32'(got), 32'(3));
        #2 reset = 1'b0;
        #1;
        check("async_reset valid_out", 32'(vld_s[1]), 32'(0));
        check("async_reset busy", 32'(bsy_s[1]), 32'(0));
        check("async_reset empty", 32'(emp_s[1]), 32'(1));
        check("async_reset data_out", 32'(do_q), 32'(0));
        @(negedge clk);
        reset = 1'b1;
        ref_q = '{0, 1};
        run_frame(1, 1'b0, "after_reset");

        // DEPTH+3 writes: the extra three are dropped.
        ref_q = {};
        for (int i = 0; i < DEP + 3; i++) ref_q.push_back(1'($urandom_range(0, 1)));
        run_frame(1, 1'b0, "full");
`ifdef RAM_MAP_OVF_EN
        check("full overflow", 32'(ovf_s[1]), 32'(1));
        check("other overflow", 32'(ovf_s[0]), 32'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
